pulse_meter: RTL and testbench

- Receive side of the LED blink interface: samples an asynchronous 1-bit pulse train (e.g. a looped-back LED1 pin) on CLK.
- Measures high time, low time and period in CLK cycles; publishes each complete period with a one-cycle valid strobe.
- Used on-board to self-check blink/desync patterns produced by top, and in simulation as a bench-side checker.

---
 rtl/pulse_meter.sv | 168 ++++++++++++++++
 tb/tb_pulse_meter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meter.sv
// pulse_meter: measures high time, low time and period of an asynchronous
// pulse train in clk cycles and publishes each complete period with a
// one-cycle VALID strobe.
//
// state | meaning
// IDLE  | after reset: wait for the synchronizer to fill and the input to read low
// ARMED | input known low, waiting for the rise that opens the first period
// HIGH  | counting the high phase in hc
// LOW   | counting the low phase in lc; the next rise closes the period
//
// SYNC_STAGES is legal in the range 2..4.
module pulse_meter #(
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIG_IN,
    output logic [CNT_W-1:0] HIGH_CNT,
    output logic [CNT_W-1:0] LOW_CNT,
    output logic [CNT_W:0]   PERIOD,
    output logic             VALID,
    output logic             SAT,
    output logic             LEVEL
);

    typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] warm_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;
    logic                   primed;

    state_t           state, state_next;
    logic [CNT_W-1:0] hc, hc_next;
    logic [CNT_W-1:0] lc, lc_next;
    logic             sat, sat_next;
    logic             cap_load;

    logic [CNT_W-1:0] cap_h;
    logic [CNT_W-1:0] cap_l;
    logic             cap_sat;
    logic             pub_req;

    assign s      = sync_q[SYNC_STAGES-1];
    // warm_q fills with ones alongside sync_q, so primed means s reflects
    // the real input rather than the reset value of the synchronizer.
    assign primed = warm_q[SYNC_STAGES-1];
    assign rise   = s & ~s_d;
    assign fall   = ~s & s_d;
    assign LEVEL  = s;

    // Input synchronizer, edge-detect delay and synchronizer warm-up tracker.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
            warm_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], SIG_IN};
            warm_q <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            s_d    <= s;
        end
    end

    // FSM state and phase counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            hc    <= '0;
            lc    <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_next;
            hc    <= hc_next;
            lc    <= lc_next;
            sat   <= sat_next;
        end
    end

    // Next-state and counter update; sat is raised when a counter already
    // at full scale is asked to count again.
    always_comb begin
        state_next = state;
        hc_next    = hc;
        lc_next    = lc;
        sat_next   = sat;
        cap_load   = 1'b0;
        unique case (state)
            IDLE: begin
                if (primed && !s) state_next = ARMED;
            end
            ARMED: begin
                if (rise) begin
                    hc_next    = CNT_ONE;
                    sat_next   = 1'b0;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    lc_next    = CNT_ONE;
                    state_next = LOW;
                end else if (hc == CNT_MAX) begin
                    sat_next = 1'b1;
                end else begin
                    hc_next = hc + CNT_ONE;
                end
            end
            LOW: begin
                if (rise) begin
                    cap_load   = 1'b1;
                    hc_next    = CNT_ONE;
                    sat_next   = 1'b0;
                    state_next = HIGH;
                end else if (lc == CNT_MAX) begin
                    sat_next = 1'b1;
                end else begin
                    lc_next = lc + CNT_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the finished period before hc is reloaded for the next one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cap_h   <= '0;
            cap_l   <= '0;
            cap_sat <= 1'b0;
            pub_req <= 1'b0;
        end else begin
            pub_req <= cap_load;
            if (cap_load) begin
                cap_h   <= hc;
                cap_l   <= lc;
                cap_sat <= sat;
            end
        end
    end

    // Publish registers; values hold until the next strobe or reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            HIGH_CNT <= '0;
            LOW_CNT  <= '0;
            PERIOD   <= '0;
            SAT      <= 1'b0;
            VALID    <= 1'b0;
        end else begin
            VALID <= pub_req;
            if (pub_req) begin
                HIGH_CNT <= cap_h;
                LOW_CNT  <= cap_l;
                PERIOD   <= {1'b0, cap_h} + {1'b0, cap_l};
                SAT      <= cap_sat;
            end
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Scoreboard bench for pulse_meter: stimulus pushes hand-computed expected
// measurements, monitors pop and compare on every VALID.
module tb_pulse_meter;

    typedef struct {
        int   h_min;
        int   h_max;
        int   l_min;
        int   l_max;
        int   per;
        int   sat;
        logic chk_lat;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SIG_IN = 1'b0;
    logic        sig4 = 1'b0;

    logic [23:0] hi_cnt, lo_cnt;
    logic [24:0] per;
    logic        valid, sat, level;
    logic [3:0]  hi4, lo4;
    logic [4:0]  per4;
    logic        valid4, sat4, level4;

    exp_t q[$];
    exp_t q4[$];
    exp_t e, e4;
    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;
    int   rise_edge = 0;
    int   rise_edge4 = 0;
    logic rst_q = 1'b0;

    pulse_meter #(.CNT_W(24), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .SIG_IN(SIG_IN),
        .HIGH_CNT(hi_cnt), .LOW_CNT(lo_cnt), .PERIOD(per),
        .VALID(valid), .SAT(sat), .LEVEL(level)
    );

    pulse_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .CLK(CLK), .RST(RST), .SIG_IN(sig4),
        .HIGH_CNT(hi4), .LOW_CNT(lo4), .PERIOD(per4),
        .VALID(valid4), .SAT(sat4), .LEVEL(level4)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        edge_cnt <= edge_cnt + 1;
        rst_q    <= RST;
    end

    task automatic check(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    task automatic check_meas(input string tag, input exp_t x, input int h, input int l,
                              input int p, input int s, input int lat);
        check({tag, "_high"}, h, x.h_min, x.h_max);
        check({tag, "_low"}, l, x.l_min, x.l_max);
        check({tag, "_period"}, p, x.per, x.per);
        check({tag, "_period_sum"}, p, h + l, h + l);
        check({tag, "_sat"}, s, x.sat, x.sat);
        if (x.chk_lat) check({tag, "_latency"}, lat, 4, 4);
    endtask

    function automatic exp_t mk(input int h_min, input int h_max, input int l_min,
                                input int l_max, input int p, input int s, input logic lat);
        exp_t x;
        x.h_min = h_min; x.h_max = h_max;
        x.l_min = l_min; x.l_max = l_max;
        x.per = p; x.sat = s; x.chk_lat = lat;
        return x;
    endfunction

    // Monitor for the 24-bit instance, sampled 1 ns after the active edge.
    always @(posedge CLK) begin
        #1;
        if (rst_q) begin
            check("valid_during_reset", int'(valid), 0, 0);
        end else if (valid) begin
            check("valid_expected", q.size(), 1, 1000);
            if (q.size() > 0) begin
                e = q.pop_front();
                check_meas("meas", e, int'(hi_cnt), int'(lo_cnt), int'(per), int'(sat),
                           edge_cnt - rise_edge);
            end
        end
    end

    // Monitor for the 4-bit instance.
    always @(posedge CLK) begin
        #1;
        if (rst_q) begin
            check("valid4_during_reset", int'(valid4), 0, 0);
        end else if (valid4) begin
            check("valid4_expected", q4.size(), 1, 1000);
            if (q4.size() > 0) begin
                e4 = q4.pop_front();
                check_meas("meas4", e4, int'(hi4), int'(lo4), int'(per4), int'(sat4),
                           edge_cnt - rise_edge4);
            end
        end
    end

    task automatic phase(input logic lvl, input int n);
        if (lvl && !SIG_IN) rise_edge = edge_cnt;
        SIG_IN = lvl;
        repeat (n) @(negedge CLK);
    endtask

    task automatic phase4(input logic lvl, input int n);
        if (lvl && !sig4) rise_edge4 = edge_cnt;
        sig4 = lvl;
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        repeat (n) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_high"}, int'(hi_cnt), 0, 0);
        check({tag, "_low"}, int'(lo_cnt), 0, 0);
        check({tag, "_period"}, int'(per), 0, 0);
        check({tag, "_valid"}, int'(valid), 0, 0);
        check({tag, "_sat"}, int'(sat), 0, 0);
        check({tag, "_level"}, int'(level), 0, 0);
    endtask

    function automatic int pick_off();
        int v;
        v = int'($urandom_range(1, 8));
        return (v >= 5) ? v + 1 : v;
    endfunction

    initial begin
        int r;
        int f;
        @(negedge CLK);

        // Reset held 3 cycles with the input toggling.
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            SIG_IN = ~SIG_IN;
            @(negedge CLK);
            check_zero("reset");
        end
        SIG_IN = 1'b0;
        RST = 1'b0;

        // Square wave 3 high / 5 low: 5 rises close 4 periods.
        phase(1'b0, 5);
        for (int i = 0; i < 4; i++) begin
            q.push_back(mk(3, 3, 5, 5, 8, 0, 1'b1));
            phase(1'b1, 3);
            phase(1'b0, 5);
        end
        phase(1'b1, 3);
        phase(1'b0, 8);
        check("square_drain", q.size(), 0, 0);

        // Input high through reset release: partial period is dropped.
        RST = 1'b1;
        SIG_IN = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        phase(1'b1, 10);
        phase(1'b0, 2);
        q.push_back(mk(2, 2, 2, 2, 4, 0, 1'b1));
        phase(1'b1, 2);
        phase(1'b0, 2);
        phase(1'b1, 2);
        phase(1'b0, 6);
        check("release_high_drain", q.size(), 0, 0);

        // 4-bit counters: 20 high saturates at 15, next 2/2 period clean.
        SIG_IN = 1'b0;
        do_reset(2);
        phase4(1'b0, 5);
        q4.push_back(mk(15, 15, 3, 3, 18, 1, 1'b1));
        q4.push_back(mk(2, 2, 2, 2, 4, 0, 1'b1));
        phase4(1'b1, 20);
        phase4(1'b0, 3);
        phase4(1'b1, 2);
        phase4(1'b0, 2);
        phase4(1'b1, 2);
        phase4(1'b0, 6);
        check("sat_drain", q4.size(), 0, 0);

        // Reset pulsed mid-LOW discards the open period.
        do_reset(2);
        phase(1'b0, 5);
        q.push_back(mk(3, 3, 5, 5, 8, 0, 1'b1));
        phase(1'b1, 3);
        phase(1'b0, 5);
        phase(1'b1, 3);
        phase(1'b0, 6);
        check("pre_midreset_drain", q.size(), 0, 0);
        RST = 1'b1;
        @(negedge CLK);
        check_zero("midreset");
        RST = 1'b0;
        phase(1'b0, 3);
        q.push_back(mk(4, 4, 6, 6, 10, 0, 1'b1));
        phase(1'b1, 4);
        phase(1'b0, 6);
        phase(1'b1, 3);
        phase(1'b0, 6);
        check("midreset_drain", q.size(), 0, 0);

        // Asynchronous edges: fixed rise offset, random fall offsets, 7/9 duty.
        do_reset(2);
        phase(1'b0, 3);
        r = pick_off();
        for (int k = 0; k < 5; k++) q.push_back(mk(6, 8, 8, 10, 16, 0, 1'b0));
        for (int k = 0; k < 6; k++) begin
            f = pick_off();
            #(r);
            SIG_IN = 1'b1;
            #(70 - r + f);
            SIG_IN = 1'b0;
            #(90 - f);
        end
        repeat (6) @(negedge CLK);

        check("final_drain", q.size(), 0, 0);
        check("final_drain4", q4.size(), 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
